vga_controller: RTL and testbench
=================================

// Module: vga_controller
// PURPOSE
//  Generates 640x480@60Hz VGA timing from the 100 MHz board clock. Divides the clock to a 25 MHz pixel
//  enable and runs horizontal/vertical counters. Produces the sync pulses, the visible-area flag and the
//  current pixel coordinates. Sits directly upstream of pixel_generation, which consumes video_on/x/y and
//  returns rgb. That module derives its 60 Hz refresh tick from y==481 && x==0.
// PARAMETERS
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT     16  horizontal front porch (pixels)
//  H_SYNC      96  hsync pulse width (pixels)
//  H_BACK      48  horizontal back porch (pixels); H_TOTAL = sum = 800
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT     10  vertical front porch (lines)
//  V_SYNC       2  vsync pulse width (lines)
//  V_BACK      33  vertical back porch (lines); V_TOTAL = sum = 525
//  CLK_DIV      4  system clocks per pixel (power of two, >=2)
// PORTS
//  clk         in   1   100 MHz system clock, all logic on rising edge
//  reset       in   1   synchronous, active-low reset (0 = reset)
//  hsync       out  1   horizontal sync, active low
//  vsync       out  1   vertical sync, active low
//  video_on    out  1   1 while (x < H_DISPLAY) && (y < V_DISPLAY)
//  p_tick      out  1   one-clk pulse per pixel (every CLK_DIV clks)
//  frame_tick  out  1   one-clk pulse when counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0)
//  x           out  10  current horizontal count, 0..H_TOTAL-1
//  y           out  10  current vertical count, 0..V_TOTAL-1
// BEHAVIOUR
//  - Reset (sampled at clk edge with reset==0): div_cnt=0, x=0, y=0, hsync=1, vsync=1, p_tick=0,
//    frame_tick=0. video_on is combinational from x/y, so it reads 1 in reset.
//  - Reset mid-frame: all state returns to the reset values on the next edge. No partial line is completed.
//  - Divider: div_cnt increments by 1 mod CLK_DIV every clk. p_tick is asserted while div_cnt==CLK_DIV-1,
//    so it is high for exactly 1 clk in CLK_DIV.
//  - Counters advance only on edges where p_tick==1. Otherwise x and y hold, so each (x,y) pair is stable
//    for CLK_DIV clks.
//  - Horizontal: x==H_TOTAL-1 -> x<=0 and the vertical step occurs, else x<=x+1.
//  - Vertical step: y==V_TOTAL-1 -> y<=0, else y<=y+1. It happens only on the horizontal wrap.
//  - frame_tick is a registered output. It is 1 for the single clk in which x==0 && y==0 immediately after
//    the counters wrap from (H_TOTAL-1, V_TOTAL-1). It is not asserted by reset.
//  - Sync outputs are registered from the next-state counter values, so they align with x/y (no lag).
//    Windows are inclusive:
//      hsync = 0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751)
//      vsync = 0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491)
//  - Widths: x and y are 10-bit unsigned. H_TOTAL and V_TOTAL must be <= 1024. Comparisons are unsigned.
//  - Simultaneous wraps: at (799,524) with p_tick, both counters wrap on the same edge. There is no
//    intermediate (0,525) state.
//  - Frame period = H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clks.
// TESTING
//  1. Hold reset=0 for 5 clks -> x=0, y=0, hsync=1, vsync=1, p_tick=0, frame_tick=0, video_on=1.
//  2. Release reset, count clks -> p_tick on every 4th clk (first pulse 3 clks after release);
//     x=1 first appears after 4 clks.
//  3. Run one line -> hsync low for exactly 96*4=384 clks, covering x 656..751; x wraps 799->0;
//     y increments 0->1 on that same edge.
//  4. Run one frame -> vsync low while y in 490..491 (2*800*4=6400 clks); video_on low for
//     x>=640 or y>=480; (y==481, x==0) occurs once per frame.
//  5. Run to (799,524) -> next p_tick edge gives x=0, y=0, frame_tick=1 for 1 clk;
//     next frame_tick 1,680,000 clks later.
//  6. Assert reset at x=300, y=200 -> next edge x=0, y=0, hsync=1, vsync=1;
//     timing restarts as in test 2 after release.

Source files
------------

// File: rtl/vga_controller.sv
// VGA timing generator: pixel-rate divider, h/v counters, sync pulses, visible-area flag, coordinates.
// Latency: syncs and frame_tick are registered from next-state counts, so they line up with x/y. No lag.
// Backpressure: none. The block is a free-running timing source.
//
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   reset      synchronous, active-low reset (0 = reset)
//   hsync      horizontal sync, active low
//   vsync      vertical sync, active low
//   video_on   combinational flag: x and y both inside the visible area
//   p_tick     one-clk pulse per pixel, every CLK_DIV clks
//   frame_tick one-clk pulse on the (H_TOTAL-1, V_TOTAL-1) -> (0,0) wrap
//   x, y       current horizontal / vertical counts
module vga_controller #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]       HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]       HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]       VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]       VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             h_wrap;
  logic             frame_wrap;

  // CLK_DIV is a power of two, so the divider wraps by natural overflow.
  assign p_tick     = (div_cnt == DIV_MAX);
  assign h_wrap     = p_tick && (x == H_MAX);
  assign frame_wrap = h_wrap && (y == V_MAX);
  assign video_on   = (x < H_VIS) && (y < V_VIS);

  // Both counters step on the same pixel edge at the frame corner, so there is
  // never an intermediate (0, V_TOTAL) state.
  always_comb begin
    x_next = x;
    y_next = y;
    if (p_tick) begin
      if (x == H_MAX) begin
        x_next = '0;
        y_next = (y == V_MAX) ? 10'd0 : y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt    <= '0;
      x          <= '0;
      y          <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
      x          <= x_next;
      y          <= y_next;
      // Decoding the next-state counts keeps the sync edges aligned with x/y.
      hsync      <= !((x_next >= HS_START) && (x_next <= HS_END));
      vsync      <= !((y_next >= VS_START) && (y_next <= VS_END));
      frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller. The DUT is built with a scaled-down timing set so
// whole frames fit in a short run:
//   H: display 8, front 2, sync 3, back 2 -> H_TOTAL 15, hsync low for x 10..12
//   V: display 6, front 2, sync 2, back 1 -> V_TOTAL 11, vsync low for y 8..9
//   CLK_DIV 4 -> line = 60 clks, frame = 660 clks
// After reset is released, n counts clk edges. Expected outputs come from n alone:
//   pixel index p = n/4, x = p % 15, y = (p/15) % 11, p_tick = (n%4 == 3),
//   frame_tick = (n > 0 && n%660 == 0).
module tb_vga_controller;

  localparam int HT = 15;
  localparam int VT = 11;
  localparam int DV = 4;
  localparam int FRAME = HT * VT * DV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hsync, vsync, video_on, p_tick, frame_tick;
  logic [9:0] x, y;

  int checks = 0;
  int errors = 0;

  vga_controller #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(DV)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .p_tick(p_tick), .frame_tick(frame_tick),
    .x(x), .y(y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the closed-form timing for n clks after release.
  task automatic check_at(input int n);
    int p, ex, ey;
    p  = n / DV;
    ex = p % HT;
    ey = (p / HT) % VT;
    check("x", 32'(x), 32'(ex));
    check("y", 32'(y), 32'(ey));
    check("p_tick", 32'(p_tick), 32'(n % DV == DV - 1));
    check("frame_tick", 32'(frame_tick), 32'(n > 0 && n % FRAME == 0));
    check("hsync", 32'(hsync), 32'(!(ex >= 10 && ex <= 12)));
    check("vsync", 32'(vsync), 32'(!(ey >= 8 && ey <= 9)));
    check("video_on", 32'(video_on), 32'(ex < 8 && ey < 6));
  endtask

  initial begin
    int hs_low, vs_low, row7_hits, ft_count, first_ft, second_ft, waited;
    logic prev_row7, row7;

    // Reset held for 5 clks.
    reset = 1'b0;
    repeat (5) tick();
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_p_tick", 32'(p_tick), 0);
    check("rst_frame_tick", 32'(frame_tick), 0);
    check("rst_video_on", 32'(video_on), 1);

    // Release and run just over two frames, checking every clk.
    reset = 1'b1;
    hs_low = 0; vs_low = 0; row7_hits = 0; ft_count = 0;
    first_ft = -1; second_ft = -1; prev_row7 = 1'b0;
    for (int n = 1; n <= 2 * FRAME + 20; n++) begin
      tick();
      check_at(n);
      if (n == 3) check("first_p_tick", 32'(p_tick), 1);
      if (n == 4) check("x_one_at_4", 32'(x), 1);
      if (n == 59) check("x_799_analog", 32'(x), 14);
      if (n == 60) begin
        check("line_wrap_x", 32'(x), 0);
        check("line_wrap_y", 32'(y), 1);
      end
      if (n <= 60 && !hsync) hs_low++;
      if (n <= FRAME && !vsync) vs_low++;
      row7 = (y == 10'd7) && (x == 10'd0);
      if (n <= 2 * FRAME && row7 && !prev_row7) row7_hits++;
      prev_row7 = row7;
      if (frame_tick) begin
        ft_count++;
        if (first_ft < 0) first_ft = n;
        else if (second_ft < 0) second_ft = n;
      end
    end
    check("hsync_low_clks", 32'(hs_low), 12);
    check("vsync_low_clks", 32'(vs_low), 120);
    check("row7_x0_per_2frames", 32'(row7_hits), 2);
    check("frame_tick_count", 32'(ft_count), 2);
    check("first_frame_tick", 32'(first_ft), FRAME);
    check("frame_tick_period", 32'(second_ft - first_ft), FRAME);

    // Mid-frame reset at (5,4).
    waited = 0;
    while (!(x == 10'd5 && y == 10'd4) && waited < 2 * FRAME) begin
      tick();
      waited++;
    end
    check("reach_5_4_in_budget", 32'(waited < 2 * FRAME), 1);
    reset = 1'b0;
    tick();
    check("mid_rst_x", 32'(x), 0);
    check("mid_rst_y", 32'(y), 0);
    check("mid_rst_hsync", 32'(hsync), 1);
    check("mid_rst_vsync", 32'(vsync), 1);
    check("mid_rst_p_tick", 32'(p_tick), 0);
    check("mid_rst_frame_tick", 32'(frame_tick), 0);
    tick();

    // Timing restarts from scratch after release.
    reset = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      tick();
      check_at(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
